// File: rtl/mdu_unit_pkg.sv
// mdu_defs: MDUControl encoding and FSM states shared by the decoder and the MDU.
package mdu_defs;
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;
endpackage

// File: rtl/mdu_divcore.sv
// mdu_divcore: combinational 32-bit signed/unsigned divider with MIPS-style
// divide-by-zero and INT_MIN/-1 results.
module mdu_divcore (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);
    logic        w_neg_a, w_neg_b, w_b_zero, w_ovf;
    logic [31:0] w_abs_a, w_abs_b, w_uq, w_ur;
    assign w_neg_a  = i_signed & i_a[31];
    assign w_neg_b  = i_signed & i_b[31];
    assign w_abs_a  = w_neg_a ? -i_a : i_a;
    assign w_abs_b  = w_neg_b ? -i_b : i_b;
    assign w_b_zero = i_b == 32'd0;
    assign w_ovf    = i_signed && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
    // Magnitude divide; the zero-divisor lane is masked below, so its value is irrelevant.
    assign w_uq     = w_b_zero ? 32'd0 : w_abs_a / w_abs_b;
    assign w_ur     = w_b_zero ? 32'd0 : w_abs_a % w_abs_b;
    assign o_quo    = w_b_zero ? 32'hFFFF_FFFF : w_ovf ? 32'h8000_0000 :
                      (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    assign o_rem    = w_b_zero ? i_a : w_ovf ? 32'd0 : w_neg_a ? -w_ur : w_ur;
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MIPS multiply/divide unit owning HI/LO; result is computed
// at the start edge and committed after a fixed busy window.
module mdu_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUControl,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    mdu_state_e  r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
    logic [31:0] w_quo, w_rem, w_res_hi, w_res_lo;
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_idle_start, w_is_mul, w_is_div, w_go;
    mdu_op_e     w_op;
    assign w_op         = mdu_op_e'(MDUControl);
    assign w_idle_start = start && r_state == IDLE;
    assign w_is_mul     = w_op == MDU_MULT || w_op == MDU_MULTU;
    assign w_is_div     = w_op == MDU_DIV || w_op == MDU_DIVU;
    assign w_go         = w_idle_start && (w_is_mul || w_is_div);
    assign w_prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u     = {32'd0, A} * {32'd0, B};
    mdu_divcore u_div (
        .i_a     (A),
        .i_b     (B),
        .i_signed(w_op == MDU_DIV),
        .o_quo   (w_quo),
        .o_rem   (w_rem)
    );
    assign w_res_hi = w_op == MDU_MULT ? w_prod_s[63:32] : w_op == MDU_MULTU ? w_prod_u[63:32] : w_rem;
    assign w_res_lo = w_op == MDU_MULT ? w_prod_s[31:0]  : w_op == MDU_MULTU ? w_prod_u[31:0]  : w_quo;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (w_go ? RUN : IDLE) : (r_cnt == CW'(1) ? IDLE : RUN);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_go) begin
            r_cnt     <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_idle_start && w_op == MDU_MTHI) begin
            r_hi <= A;
        end else if (w_idle_start && w_op == MDU_MTLO) begin
            r_lo <= A;
        end
    end
    assign busy = r_state == RUN;
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, beside the ALU.
- Fed by the same forwarded A/B operands that drive the ALU.
- Owns the architectural HI/LO registers and drives a busy signal that the hazard unit uses to stall MDU-dependent instructions in D.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI/MFLO read the HI/LO outputs directly.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (>=1).
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- A  in  32  rs operand, forwarded.
- B  in  32  rt operand, forwarded.
- MDUControl  in  3  operation code; see package encoding.
- start  in  1  qualifies MDUControl this cycle. Already gated by EX flush/exception.
- busy  out  1  operation in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state, while reset_n=0: HI=0, LO=0, busy=0, counter=0, pending results=0, FSM=IDLE.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1, MDUControl in {MULT, MULTU, DIV, DIVU}:
  - Compute the 64-bit result at this edge and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - busy is high from the next cycle for exactly N cycles.
- RUN: each edge decrements counter. At the edge where counter==1:
  - HI<=pending_hi, LO<=pending_lo, counter<=0.
  - busy<=0, go to IDLE.
  - HI/LO are first visible in the same cycle busy drops.
- IDLE, start=1, MTHI: HI<=A at that edge. LO unchanged, busy stays 0.
- IDLE, start=1, MTLO: LO<=A at that edge. HI unchanged, busy stays 0.
- Any start while in RUN is ignored: no state change, HI/LO untouched. Verification asserts it never occurs, since the hazard unit stalls on busy.
- start=1 with MDUControl=NONE or an unused code: no effect.
- MULT: signed 32x32 -> 64. {HI,LO} = product.
- MULTU: unsigned 32x32 -> 64. {HI,LO} = product.
- DIV: signed division, truncating toward zero.
  - LO = quotient.
  - HI = remainder, with the sign of the dividend.
- DIVU: unsigned division. LO = quotient, HI = remainder.
- Divide by zero, both DIV and DIVU: LO=32'hFFFFFFFF, HI=A. No exception.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0. No exception.
- MDU ops raise no overflow.
- Operands are sampled only at the start edge. A/B changing during RUN has no effect.
- HI/LO outputs are driven directly from the registers, no combinational bypass. A same-cycle MTHI followed by MFHI relies on the pipeline's forwarding, not on this block.
- Reset asserted mid-RUN: immediately returns to the reset state. The pending result is discarded.

Decomposition:
- Shared package mdu_defs holds the MDUControl encoding:
  - MDU_NONE=3'd0, MDU_MULT=3'd1, MDU_MULTU=3'd2, MDU_DIV=3'd3, MDU_DIVU=3'd4, MDU_MTHI=3'd5, MDU_MTLO=3'd6.
  - The decoder and this block both use it.
- The package also defines the FSM state constants IDLE/RUN.
- One natural sub-module: mdu_divcore, a combinational signed/unsigned divider with the zero and overflow special cases. It isolates the corner-case logic for separate unit testing.
- The multiply stays inline.

Test Plan:
- MULT A=32'hFFFFFFFF, B=32'h00000002:
  - busy high for 5 cycles.
  - Then HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
- MULTU, same operands: HI=32'h00000001, LO=32'hFFFFFFFE after 5 busy cycles.
- DIV A=-7 (32'hFFFFFFF9), B=2:
  - busy for 10 cycles.
  - LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- DIVU A=7, B=0:
  - LO=32'hFFFFFFFF, HI=32'h00000007.
  - Follow with DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- MTHI A=32'h12345678, then MTLO A=32'h9ABCDEF0, back to back:
  - HI/LO update one edge after each start.
  - busy stays 0.
  - A start pulse injected mid-MULT is ignored and the MULT result commits unchanged.
- Start DIV, deassert reset_n at busy cycle 4:
  - busy=0, HI=LO=0 immediately.
  - After release, no stale result ever commits.
